// File: rtl/bits32_demux_pkg.sv
// Shared constants and types for the 32-bit 1-to-4 registered distributor.
package bits32_demux_pkg;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    localparam ch_sel_t CH0 = 2'b00;
    localparam ch_sel_t CH1 = 2'b01;
    localparam ch_sel_t CH2 = 2'b10;
    localparam ch_sel_t CH3 = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Target mask for one transfer: every channel on broadcast, else one-hot of sel.
    function automatic logic [NUM_CH-1:0] ch_target(input ch_sel_t sel, input logic bcast);
        logic [NUM_CH-1:0] mask;
        mask = '0;
        if (bcast) begin
            mask = '1;
        end else begin
            mask[sel] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bits32_demux1to4_slot.sv
// One-entry holding register for a single output channel; the state bit is out_valid.
module demux_slot
    import bits32_demux_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] dout,
    output logic         free
);

    slot_state_t  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = din;
                end
            end
            SLOT_FULL: begin
                // A load in a draining cycle replaces the word, so no bubble.
                if (load) begin
                    data_d = din;
                end else if (out_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign dout      = data_q;
    assign free      = ~out_valid | out_ready;

endmodule

// File: rtl/bits32_demux1to4.sv
// Registered 1-to-4 distributor: steers or broadcasts one word per cycle into four
// independently stalled channel slots.
module bits32_demux1to4
    import bits32_demux_pkg::*;
#(
    parameter int WIDTH = bits32_demux_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] In_data,
    input  logic [1:0]       Select,
    input  logic             Broadcast,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Out_data0,
    output logic [WIDTH-1:0] Out_data1,
    output logic [WIDTH-1:0] Out_data2,
    output logic [WIDTH-1:0] Out_data3,
    output logic [3:0]       Out_valid,
    input  logic [3:0]       Out_ready
);

    logic [NUM_CH-1:0]            free;
    logic [NUM_CH-1:0]            load_en;
    logic [NUM_CH-1:0][WIDTH-1:0] slot_data;
    logic                         accept;

    // Broadcast needs every slot free so a word never lands in a subset of channels.
    assign In_ready = Broadcast ? (&free) : free[Select];
    assign accept   = In_valid & In_ready;
    assign load_en  = accept ? ch_target(ch_sel_t'(Select), Broadcast) : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(
            .W (WIDTH)
        ) u_slot (
            .clk       (clk),
            .resetn    (resetn),
            .load      (load_en[g]),
            .din       (In_data),
            .out_ready (Out_ready[g]),
            .out_valid (Out_valid[g]),
            .dout      (slot_data[g]),
            .free      (free[g])
        );
    end

    assign Out_data0 = slot_data[CH0];
    assign Out_data1 = slot_data[CH1];
    assign Out_data2 = slot_data[CH2];
    assign Out_data3 = slot_data[CH3];

endmodule

// File: tb/tb_bits32_demux1to4.sv
// Self-checking bench for bits32_demux1to4: directed scenarios plus random traffic
// compared against a per-channel holding model.
`timescale 1ns/1ps
module tb_bits32_demux1to4;

    logic        clk;
    logic        resetn;
    logic [31:0] In_data;
    logic [1:0]  Select;
    logic        Broadcast;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Out_data0, Out_data1, Out_data2, Out_data3;
    logic [3:0]  Out_valid;
    logic [3:0]  Out_ready;

    logic [31:0] od [4];
    assign od[0] = Out_data0;
    assign od[1] = Out_data1;
    assign od[2] = Out_data2;
    assign od[3] = Out_data3;

    int total = 0;
    int bad   = 0;

    // Reference: what each channel holds and whether it is undelivered.
    logic [3:0]  m_valid;
    logic [31:0] m_data [4];

    // Words seen leaving each channel (valid & ready before an edge).
    logic [31:0] got_mem [4][16];
    int          got_n   [4];

    bits32_demux1to4 dut (
        .clk       (clk),
        .resetn    (resetn),
        .In_data   (In_data),
        .Select    (Select),
        .Broadcast (Broadcast),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Out_data0 (Out_data0),
        .Out_data1 (Out_data1),
        .Out_data2 (Out_data2),
        .Out_data3 (Out_data3),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ready();
        logic all_free;
        all_free = 1'b1;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && !Out_ready[i]) all_free = 1'b0;
        if (Broadcast) return all_free;
        return !m_valid[Select] || Out_ready[Select];
    endfunction

    function automatic void model_reset();
        m_valid = '0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
    endfunction

    // Advance one clock edge; the model steps with the inputs present before the edge.
    task automatic tick();
        logic [3:0]  nv;
        logic [31:0] nd [4];
        logic        acc;
        acc = In_valid && model_ready();
        for (int i = 0; i < 4; i++) begin
            if (Out_valid[i] && Out_ready[i] && got_n[i] < 16) begin
                got_mem[i][got_n[i]] = od[i];
                got_n[i]++;
            end
            nv[i] = m_valid[i];
            nd[i] = m_data[i];
            if (acc && (Broadcast || Select == 2'(i))) begin
                nv[i] = 1'b1;
                nd[i] = In_data;
            end else if (m_valid[i] && Out_ready[i]) begin
                nv[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        for (int i = 0; i < 4; i++) m_data[i] = nd[i];
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        In_valid = 1'b0; In_data = '0; Select = '0; Broadcast = 1'b0; Out_ready = '0;
        model_reset();
        #3;
        total++;
        if (Out_valid !== 4'b0000) begin
            bad++; $display("FAIL reset_valid got=%b exp=%b", Out_valid, 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (od[i] !== 32'h0) begin
                bad++; $display("FAIL reset_data%0d got=%h exp=%h", i, od[i], 32'h0);
            end
        end
        for (int k = 0; k < 8; k++) begin
            Select = 2'(k); Broadcast = k[2];
            #1;
            total++;
            if (In_ready !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready sel=%0d bc=%0b got=%b exp=1", Select, Broadcast, In_ready);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_single();
        Select = 2'b10; Broadcast = 1'b0; In_data = 32'hDEAD_BEEF; In_valid = 1'b1; Out_ready = '0;
        tick();
        In_valid = 1'b0;
        total++;
        if (Out_valid !== 4'b0100) begin
            bad++; $display("FAIL single_valid got=%b exp=%b", Out_valid, 4'b0100);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (od[i] !== m_data[i]) begin
                bad++; $display("FAIL single_data%0d got=%h exp=%h", i, od[i], m_data[i]);
            end
        end
        Out_ready = 4'b1111;
        tick();
        Out_ready = '0;
    endtask

    task automatic test_stall_replace();
        Select = 2'b01; In_data = 32'hA1A1_0001; In_valid = 1'b1; Out_ready = '0;
        tick();
        In_data = 32'h0000_0099;
        #1;
        total++;
        if (In_ready !== 1'b0) begin
            bad++; $display("FAIL stall_in_ready got=%b exp=0", In_ready);
        end
        tick();
        total++;
        if (Out_data1 !== 32'hA1A1_0001 || Out_valid[1] !== 1'b1) begin
            bad++; $display("FAIL stall_hold got=%h/%b exp=%h/1", Out_data1, Out_valid[1], 32'hA1A1_0001);
        end
        Out_ready = 4'b0010; In_data = 32'h0000_0005;
        #1;
        total++;
        if (In_ready !== 1'b1) begin
            bad++; $display("FAIL replace_in_ready got=%b exp=1", In_ready);
        end
        tick();
        In_valid = 1'b0; Out_ready = '0;
        total++;
        if (Out_valid[1] !== 1'b1 || Out_data1 !== 32'h0000_0005) begin
            bad++; $display("FAIL replace got=%h/%b exp=%h/1", Out_data1, Out_valid[1], 32'h5);
        end
        total++;
        if (got_n[1] < 1 || got_mem[1][got_n[1]-1] !== 32'hA1A1_0001) begin
            bad++; $display("FAIL replace_drained n=%0d exp old word %h", got_n[1], 32'hA1A1_0001);
        end
        Out_ready = 4'b1111;
        tick();
        Out_ready = '0;
    endtask

    task automatic test_broadcast();
        Select = 2'b11; Broadcast = 1'b0; In_data = 32'hCAFE_0003; In_valid = 1'b1; Out_ready = '0;
        tick();
        Broadcast = 1'b1; In_data = 32'h1234_5678; Select = 2'b00;
        #1;
        total++;
        if (In_ready !== 1'b0) begin
            bad++; $display("FAIL bcast_blocked_ready got=%b exp=0", In_ready);
        end
        tick();
        total++;
        if (Out_valid !== 4'b1000 || Out_data3 !== 32'hCAFE_0003) begin
            bad++; $display("FAIL bcast_no_load got=%b/%h exp=1000/%h", Out_valid, Out_data3, 32'hCAFE_0003);
        end
        Out_ready = 4'b1000;
        #1;
        total++;
        if (In_ready !== 1'b1) begin
            bad++; $display("FAIL bcast_release_ready got=%b exp=1", In_ready);
        end
        tick();
        In_valid = 1'b0; Broadcast = 1'b0; Out_ready = '0;
        total++;
        if (Out_valid !== 4'b1111) begin
            bad++; $display("FAIL bcast_valid got=%b exp=1111", Out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (od[i] !== 32'h1234_5678) begin
                bad++; $display("FAIL bcast_data%0d got=%h exp=%h", i, od[i], 32'h1234_5678);
            end
        end
        Out_ready = 4'b1111;
        tick();
        Out_ready = '0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) got_n[i] = 0;
        Out_ready = 4'b1111; Broadcast = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            Select = 2'((k - 1) % 4); In_data = 32'(k); In_valid = 1'b1;
            #1;
            total++;
            if (In_ready !== 1'b1) begin
                bad++; $display("FAIL stream_ready word=%0d got=%b exp=1", k, In_ready);
            end
            tick();
        end
        In_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_n[i] !== 2 || got_mem[i][0] !== 32'(i + 1) || got_mem[i][1] !== 32'(i + 5)) begin
                bad++; $display("FAIL stream_ch%0d n=%0d got=%0d,%0d exp=%0d,%0d",
                                i, got_n[i], got_mem[i][0], got_mem[i][1], i + 1, i + 5);
            end
        end
        Out_ready = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            In_data   = $urandom;
            Select    = 2'($urandom_range(0, 3));
            Broadcast = ($urandom_range(0, 7) == 0);
            In_valid  = ($urandom_range(0, 3) != 0);
            Out_ready = 4'($urandom);
            #1;
            total++;
            if (In_ready !== model_ready()) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, In_ready, model_ready());
            end
            tick();
            total++;
            if (Out_valid !== m_valid) begin
                bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, Out_valid, m_valid);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_valid[i]) begin
                    total++;
                    if (od[i] !== m_data[i]) begin
                        bad++; $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", i, c, od[i], m_data[i]);
                    end
                end
            end
        end
        In_valid = 1'b0; Broadcast = 1'b0;
    endtask

    task automatic test_reset_mid();
        Out_ready = '0; Broadcast = 1'b0; In_valid = 1'b1;
        Select = 2'b00; In_data = 32'h0000_AAAA;
        tick();
        Select = 2'b10; In_data = 32'h0000_BBBB;
        tick();
        In_valid = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        total++;
        if (Out_valid !== 4'b0000) begin
            bad++; $display("FAIL midreset_valid got=%b exp=0000", Out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (od[i] !== 32'h0) begin
                bad++; $display("FAIL midreset_data%0d got=%h exp=0", i, od[i]);
            end
        end
        resetn = 1'b1;
        Select = 2'b11; In_data = 32'h0000_CCCC; In_valid = 1'b1;
        #1;
        total++;
        if (In_ready !== 1'b1) begin
            bad++; $display("FAIL postreset_ready got=%b exp=1", In_ready);
        end
        tick();
        In_valid = 1'b0;
        total++;
        if (Out_valid !== 4'b1000 || Out_data3 !== 32'h0000_CCCC) begin
            bad++; $display("FAIL postreset_load got=%b/%h exp=1000/%h", Out_valid, Out_data3, 32'h0000_CCCC);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) got_n[i] = 0;
        test_reset();
        test_single();
        test_stall_replace();
        test_broadcast();
        test_stream();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
